// File: rtl/nn_pkg.sv
// Shared definitions for the output layer: score width, default class count
// and the packer's state encoding. Also used by the class-index selector.
package nn_pkg;

    localparam int SCORE_W     = 8;
    localparam int DEF_N_CLASS = 10;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } pack_state_e;

endpackage : nn_pkg

// File: rtl/score_narrow.sv
// Narrows one signed neuron result to an 8-bit unsigned score.
// Optional build macro: SCORE_PACKER_SAT_EN clamps to 0..255;
// without it the shifted value is truncated to its low 8 bits.
module score_narrow
    import nn_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int SHIFT = 0
) (
    input  logic [IN_W-1:0]    in_data,
    output logic [SCORE_W-1:0] score
);

    // One extra bit so the constant 255 is representable even when IN_W is 8.
    localparam logic signed [IN_W:0] SCORE_MAX = (IN_W + 1)'(255);

    logic signed [IN_W-1:0] v;
    logic signed [IN_W:0]   v_ext;

    assign v     = $signed(in_data) >>> SHIFT;
    assign v_ext = {v[IN_W-1], v};

    // Shifted value to score: clamp or wrap depending on the build.
    always_comb begin
        // NOTE: score gets a value on every path, so no latch is inferred.
        score = v[SCORE_W-1:0];
`ifdef SCORE_PACKER_SAT_EN
        if (v[IN_W-1]) begin
            score = '0;
        end else if (v_ext > SCORE_MAX) begin
            score = '1;
        end
`endif
    end

endmodule : score_narrow

// File: rtl/score_packer.sv
// Collects one neuron result per input beat into an N_CLASS x 8-bit score
// vector (slot 0 at bits [7:0]) and holds the finished vector under an
// output valid/ready handshake. Short and long vectors raise err_len.
// Optional build macro: SCORE_PACKER_SAT_EN (saturating narrowing, see
// score_narrow); handshake and timing do not depend on it.
module score_packer
    import nn_pkg::*;
#(
    parameter int N_CLASS = DEF_N_CLASS,
    parameter int IN_W    = 16,
    parameter int SHIFT   = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [IN_W-1:0]              in_data,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [SCORE_W*N_CLASS-1:0]   array,
    output logic                         err_len
);

    localparam int CNT_W = (N_CLASS > 1) ? $clog2(N_CLASS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_CLASS - 1);

    pack_state_e                       state_q, state_d;
    logic [CNT_W-1:0]                  cnt_q, cnt_d;
    logic                              err_d;
    logic [N_CLASS-1:0][SCORE_W-1:0]   slots_q;
    logic [SCORE_W-1:0]                score;
    logic                              accept;
    logic                              cnt_last;

    score_narrow #(
        .IN_W  (IN_W),
        .SHIFT (SHIFT)
    ) u_narrow (
        .in_data (in_data),
        .score   (score)
    );

    // Handshake outputs decode the state register only.
    assign in_ready  = (state_q == FILL);
    assign out_valid = (state_q == HOLD);
    assign accept    = in_valid && in_ready;
    assign cnt_last  = (cnt_q == CNT_LAST);
    assign array     = slots_q;

    // Next-state, slot counter and length-error decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        case (state_q)
            FILL: begin
                if (accept) begin
                    if (in_last || cnt_last) begin
                        state_d = HOLD;
                        cnt_d   = '0;
                        err_d   = (in_last != cnt_last);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = FILL;
                end
            end
            default: begin
                state_d = FILL;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and error pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            cnt_q   <= '0;
            err_len <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_len <= err_d;
        end
    end

    // Slot register file: write the current slot, zero-fill above it on a short vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: this storage is reset on purpose; the score vector must read 0 after reset.
            slots_q <= '0;
        end else if (accept) begin
            for (int k = 0; k < N_CLASS; k++) begin
                if (CNT_W'(k) == cnt_q) begin
                    slots_q[k] <= score;
                end else if (in_last && (CNT_W'(k) > cnt_q)) begin
                    slots_q[k] <= '0;
                end
            end
        end
    end

endmodule : score_packer

// File: tb/tb_score_packer.sv
// Self-checking bench for score_packer: directed scenarios followed by
// randomized traffic, all compared against a vector-level reference model.
module tb_score_packer;

    localparam int N     = 10;
    localparam int IN_W  = 16;
    localparam int SHIFT = 0;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_last = 1'b0;
    logic            out_ready = 1'b0;
    logic [IN_W-1:0] in_data = '0;
    logic            in_ready;
    logic            out_valid;
    logic            err_len;
    logic [8*N-1:0]  array;

    int total = 0;
    int bad   = 0;

    // Reference model state: vector under construction and held result.
    bit             m_hold = 1'b0;
    bit             m_err  = 1'b0;
    int             m_q[$];
    logic [8*N-1:0] m_arr = '0;

    score_packer #(
        .N_CLASS (N),
        .IN_W    (IN_W),
        .SHIFT   (SHIFT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .array     (array),
        .err_len   (err_len)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int narrow(input int d);
        int v;
        v = d >>> SHIFT;
`ifdef SCORE_PACKER_SAT_EN
        if (v < 0)   return 0;
        if (v > 255) return 255;
`endif
        return v & 255;
    endfunction

    function automatic void model_reset();
        m_hold = 1'b0;
        m_err  = 1'b0;
        m_q.delete();
        m_arr  = '0;
    endfunction

    // Apply one clock edge of the specified behaviour to the model.
    function automatic void model_edge();
        m_err = 1'b0;
        if (!m_hold) begin
            if (in_valid) begin
                m_q.push_back(narrow(int'($signed(in_data))));
                if (in_last || m_q.size() == N) begin
                    m_err = !(in_last && m_q.size() == N);
                    m_arr = '0;
                    foreach (m_q[i]) m_arr[8*i +: 8] = 8'(m_q[i]);
                    m_hold = 1'b1;
                    m_q.delete();
                end
            end
        end else if (out_ready) begin
            m_hold = 1'b0;
        end
    endfunction

    task automatic check_outs(input string tag);
        check({tag, ".in_ready"},  in_ready,  !m_hold);
        check({tag, ".out_valid"}, out_valid, m_hold);
        check({tag, ".err_len"},   err_len,   m_err);
        if (m_hold) check({tag, ".array"}, array, m_arr);
    endtask

    // Drive one cycle of inputs, clock it, then compare.
    task automatic step(input string tag, input logic v, input logic last,
                        input logic [IN_W-1:0] data, input logic ordy);
        in_valid  = v;
        in_last   = last;
        in_data   = data;
        out_ready = ordy;
        @(posedge clk);
        model_edge();
        #1;
        check_outs(tag);
    endtask

    task automatic do_reset(input string tag);
        in_valid = 1'b1;
        in_last  = 1'b0;
        rst_n    = 1'b0;
        #1;
        model_reset();
        check({tag, ".rst_in_ready"},  in_ready,  1'b1);
        check({tag, ".rst_out_valid"}, out_valid, 1'b0);
        check({tag, ".rst_err_len"},   err_len,   1'b0);
        check({tag, ".rst_array"},     array,     '0);
        repeat (3) @(posedge clk);
        #1;
        check({tag, ".rst_hold_array"}, array, '0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        model_edge();
        #1;
        check_outs({tag, ".post_rst"});
    endtask

    initial begin
        logic [IN_W-1:0] d;
        logic            lst;

        do_reset("init");

        // Full vector 0..9 back to back.
        for (int i = 0; i < N; i++) step("seq", 1'b1, (i == N - 1), IN_W'(i), 1'b0);
        check("vec_0_9", array, 80'h09080706050403020100);

        // Consumer stalls while the producer keeps offering.
        for (int i = 0; i < 5; i++) step("stall", 1'b1, 1'b0, 16'h00AA, 1'b0);
        check("stall_array", array, 80'h09080706050403020100);
        step("accept", 1'b0, 1'b0, '0, 1'b1);
        check("accept_in_ready", in_ready, 1'b1);

        // Full vector of 0xFF, then a 4-beat short vector.
        for (int i = 0; i < N; i++) step("ff", 1'b1, (i == N - 1), 16'h00FF, 1'b0);
        step("ff_acc", 1'b0, 1'b0, '0, 1'b1);
        step("short", 1'b1, 1'b0, 16'h0011, 1'b0);
        step("short", 1'b1, 1'b0, 16'h0022, 1'b0);
        step("short", 1'b1, 1'b0, 16'h0033, 1'b0);
        step("short", 1'b1, 1'b1, 16'h0044, 1'b0);
        check("short_array", array, 80'h00000000000044332211);
        check("short_err", err_len, 1'b1);
        step("short_hold", 1'b0, 1'b0, '0, 1'b1);

        // Narrowing of a negative and an oversized value.
        step("narrow", 1'b1, 1'b0, 16'hFFFB, 1'b0);
        step("narrow", 1'b1, 1'b1, 16'd300, 1'b0);
`ifdef SCORE_PACKER_SAT_EN
        check("narrow_bytes", array[15:0], 16'hFF00);
`else
        check("narrow_bytes", array[15:0], 16'h2CFB);
`endif
        step("narrow_acc", 1'b0, 1'b0, '0, 1'b1);

        // Reset in the middle of a vector, then a clean vector.
        for (int i = 0; i < 6; i++) step("mid", 1'b1, 1'b0, IN_W'(16'h0050 + i), 1'b0);
        do_reset("midrst");
        for (int i = 0; i < N; i++) step("clean", 1'b1, (i == N - 1), IN_W'(16'h0060 + i), 1'b0);
        check("clean_array", array, 80'h69686766656463626160);
        step("clean_acc", 1'b0, 1'b0, '0, 1'b1);

        // Randomized traffic, including long and short vectors.
        for (int c = 0; c < 600; c++) begin
            d   = IN_W'($urandom);
            lst = (m_q.size() == N - 1) ? ($urandom_range(0, 3) != 0)
                                        : ($urandom_range(0, 11) == 0);
            step("rand", ($urandom_range(0, 9) < 7), lst, d, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_score_packer
